sw_debounce: RTL and testbench

//  Conditions raw slide-switch inputs before they reach the Nios switch PIO input port.
//  - Synchronises each bit to CLOCK_50 and debounces it with a shared tick prescaler.
//  - Per bit, flags debounced rising and falling edges.
//  - Keeps a sticky write-1-to-clear edge-capture vector that firmware polls.

---
 rtl/sw_debounce.sv | 75 +++++++
 tb/tb_sw_debounce.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// sw_debounce: synchronise, debounce and edge-detect slide switches for the PIO input port.
module sw_debounce #(
    parameter int WIDTH        = 16,
    parameter int TICK_CYCLES  = 50000,
    parameter int STABLE_TICKS = 20
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic [WIDTH-1:0] capture_clr,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             any_change,
    output logic [WIDTH-1:0] edge_capture
);
    localparam int TW = $clog2(TICK_CYCLES);

    logic [TW-1:0]           tick_cnt_q, tick_cnt_d;
    logic                    tick;
    logic [WIDTH-1:0]        s1_q, s2_q, clean_q, clean_d, rise_q, fall_q, cap_q, cap_d;
    logic                    any_q;
    logic [WIDTH-1:0][4:0]   cnt_q, cnt_d;

    always_comb begin
        tick       = tick_cnt_q == TW'(TICK_CYCLES - 1);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        clean_d    = clean_q;
        cnt_d      = cnt_q;
        // Any cycle where s2 agrees with the clean level restarts the window.
        for (int i = 0; i < WIDTH; i++) begin
            if (s2_q[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == 5'(STABLE_TICKS - 1)) begin
                    clean_d[i] = s2_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 5'd1;
                end
            end
        end
        cap_d = (cap_q & ~capture_clr) | rise_q | fall_q;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            clean_q    <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            any_q      <= 1'b0;
            cap_q      <= '0;
            cnt_q      <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            s1_q       <= sw_raw;
            s2_q       <= s1_q;
            clean_q    <= clean_d;
            rise_q     <= clean_d & ~clean_q;
            fall_q     <= ~clean_d & clean_q;
            any_q      <= |(clean_d ^ clean_q);
            cap_q      <= cap_d;
            cnt_q      <= cnt_d;
        end
    end

    assign sw_clean     = clean_q;
    assign sw_rise      = rise_q;
    assign sw_fall      = fall_q;
    assign any_change   = any_q;
    assign edge_capture = cap_q;
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: randomized and directed stimulus against a window-counting reference model.
module tb_sw_debounce;
    localparam int W  = 16;
    localparam int TC = 4;
    localparam int ST = 3;

    logic         CLOCK_50 = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sw_raw = '0, capture_clr = '0;
    logic [W-1:0] sw_clean, sw_rise, sw_fall, edge_capture;
    logic         any_change;

    sw_debounce #(.WIDTH(W), .TICK_CYCLES(TC), .STABLE_TICKS(ST)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .sw_raw(sw_raw), .capture_clr(capture_clr),
        .sw_clean(sw_clean), .sw_rise(sw_rise), .sw_fall(sw_fall),
        .any_change(any_change), .edge_capture(edge_capture)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [W-1:0] clean, rise, fall, cap;
        logic         any, tick;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int checks = 0, passes = 0;
    int rise0_n, rise3_n, fall3_n, rise5_n, fall5_n, allrise_n, any_n, fall15_n;

    logic [W-1:0] s1_m, s2_m, clean_m, rise_m, fall_m, cap_m;
    int last_eq[W];
    int k;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        {s1_m, s2_m, clean_m, rise_m, fall_m, cap_m} = '0;
        foreach (last_eq[i]) last_eq[i] = -1;
        k = 0;
    endtask

    task automatic clr_counts();
        {rise0_n, rise3_n, fall3_n, rise5_n, fall5_n, allrise_n, any_n, fall15_n} = '0;
    endtask

    // A bit flips at a tick edge once ST tick edges have passed since it last agreed with s2.
    task automatic step(input logic [W-1:0] raw, input logic [W-1:0] clr);
        logic [W-1:0] nclean;
        logic tk;
        sw_raw = raw;
        capture_clr = clr;
        tk = (k % TC) == TC - 1;
        nclean = clean_m;
        for (int i = 0; i < W; i++) begin
            if (s2_m[i] == clean_m[i]) last_eq[i] = k;
            else if (tk && ((k + 1) / TC - (last_eq[i] + 1) / TC) == ST) begin
                nclean[i] = s2_m[i];
                last_eq[i] = k;
            end
        end
        cap_m   = (cap_m & ~clr) | rise_m | fall_m;
        rise_m  = nclean & ~clean_m;
        fall_m  = ~nclean & clean_m;
        clean_m = nclean;
        s2_m    = s1_m;
        s1_m    = raw;
        k++;
        q.push_back('{clean: clean_m, rise: rise_m, fall: fall_m, cap: cap_m,
                      any: |(rise_m | fall_m), tick: (k % TC) == TC - 1});
        @(negedge CLOCK_50);
    endtask

    always @(posedge CLOCK_50) begin
        #1;
        if (!reset) begin
            rise0_n   += int'(sw_rise[0]);
            rise3_n   += int'(sw_rise[3]);
            fall3_n   += int'(sw_fall[3]);
            rise5_n   += int'(sw_rise[5]);
            fall5_n   += int'(sw_fall[5]);
            fall15_n  += int'(sw_fall[15]);
            allrise_n += int'(sw_rise == '1);
            any_n     += int'(any_change);
            if (q.size() > 0) begin
                me = q.pop_front();
                chk("sw_clean", sw_clean, me.clean);
                chk("sw_rise", sw_rise, me.rise);
                chk("sw_fall", sw_fall, me.fall);
                chk("any_change", W'(any_change), W'(me.any));
                chk("edge_capture", edge_capture, me.cap);
                chk("tick", W'(dut.tick), W'(me.tick));
            end
        end
    end

    initial begin
        int n;
        logic [W-1:0] r;
        clr_counts();
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        model_reset();
        repeat (17) step('1, '0);
        chk("pre_reset_clean", sw_clean, 16'hFFFF);
        // Test 1: reset mid-count with bit 0 held high
        sw_raw = 16'h0001;
        #2 reset = 1'b1;
        #1;
        chk("rst_clean", sw_clean, '0);
        chk("rst_rise", sw_rise, '0);
        chk("rst_fall", sw_fall, '0);
        chk("rst_any", W'(any_change), '0);
        chk("rst_cap", edge_capture, '0);
        q.delete();
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        model_reset();
        clr_counts();
        repeat (14) step(16'h0001, '0);
        chk("t1_clean", sw_clean, 16'h0001);
        chk("t1_cap", edge_capture, 16'h0001);
        chk("t1_rise0_count", W'(rise0_n), W'(1));
        // Test 2: bit 3 bounces, then settles high
        clr_counts();
        for (int j = 0; j < 20; j++) step(16'h0001 | ((j % 2 == 0) ? 16'h0008 : 16'h0000), '0);
        n = 0;
        while (!sw_clean[3] && n < 20) begin
            step(16'h0009, '0);
            n++;
        end
        checks++;
        if (n - 2 >= 9 && n - 2 <= 12) passes++;
        else $display("FAIL t2_latency: got %0d expected 9..12", n - 2);
        repeat (6) step(16'h0009, '0);
        chk("t2_rise3_count", W'(rise3_n), W'(1));
        chk("t2_fall3_count", W'(fall3_n), W'(0));
        // Test 3: short glitch on bit 5
        clr_counts();
        repeat (6) step(16'h0029, '0);
        repeat (20) step(16'h0009, '0);
        chk("t3_clean", sw_clean, 16'h0009);
        chk("t3_cap", edge_capture, 16'h0009);
        chk("t3_bit5_edges", W'(rise5_n + fall5_n), W'(0));
        // Test 4: all bits rise together
        repeat (20) step('0, '0);
        step('0, '1);
        chk("t4_cap_cleared", edge_capture, '0);
        clr_counts();
        repeat (20) step('1, '0);
        chk("t4_allrise_count", W'(allrise_n), W'(1));
        chk("t4_any_count", W'(any_n), W'(1));
        chk("t4_cap", edge_capture, 16'hFFFF);
        // Test 5: clear colliding with an edge on bit 2, then a plain clear
        step('1, 16'hFFFF);
        n = 0;
        while (!fall_m[2] && n < 30) begin
            step(16'hFFFB, '0);
            n++;
        end
        checks++;
        if (fall_m[2]) passes++;
        else $display("FAIL t5_fall_wait: no fall on bit 2 within %0d cycles", n);
        step(16'hFFFB, 16'h0004);
        chk("t5_set_wins", W'(edge_capture[2]), W'(1));
        repeat (3) step(16'hFFFB, '0);
        step(16'hFFFB, 16'h0004);
        chk("t5_cleared", edge_capture, 16'h0000);
        step(16'hFFFB, '0);
        // Test 6: fall on bit 15
        clr_counts();
        repeat (20) step(16'h7FFB, '0);
        chk("t6_fall15_count", W'(fall15_n), W'(1));
        chk("t6_cap", edge_capture, 16'h8000);
        // Randomized phase checked by the scoreboard
        r = '0;
        for (int j = 0; j < 60; j++) begin
            r = r ^ W'($urandom) & W'($urandom);
            repeat ($urandom_range(1, 16)) step(r, ($urandom_range(0, 3) == 0) ? W'($urandom) : '0);
        end
        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expected entries never consumed", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
